// File: rtl/mainfsm_if.sv
// mainfsm_if -- bundles the instruction-field inputs and the control-word
// outputs of the multicycle control FSM.
//   Op, Funct       : instruction fields fed from the instruction register
//   IRWrite..ALUOp  : control word driven by the FSM
//   State           : current FSM state, exposed for debug and checkers
// Modports:
//   master : the FSM side (drives the control word, reads Op/Funct)
//   slave  : the datapath side (drives Op/Funct, reads the control word)
interface mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;

  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );
endinterface

// File: rtl/mainfsm.sv
// mainfsm -- Moore control FSM of a multicycle ARM-style processor.
// Sequences fetch, decode, memory, execute, writeback and branch steps.
// Every output is decoded from the state register only; Op/Funct only
// steer the next-state logic.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   Op[1:0], Funct[5:0]   : instr[27:26], instr[25:20]
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
//   RegW, MemW, Branch, ALUOp : datapath control word
//   State[3:0]            : current state encoding (debug)
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  state_t r_state;
  state_t w_next;

  // Reset takes effect immediately, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic. Encodings 11-15 fall into the default and recover
  // to FETCH, the same as UNKNOWN.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   w_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
          default: w_next = UNKNOWN;
        endcase
      end
      MEMADR:   w_next = Funct[0] ? MEMRD : MEMWR;  // LDR : STR
      MEMRD:    w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  // Moore output decode: everything defaults to 0 and each state only
  // raises what it needs, so RegW/MemW/NextPC are one-hot in time.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (r_state)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        // PC+8 computed here so it can serve as R15 during execute.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm -- directed and randomised instruction sequences for mainfsm.
// For every instruction the expected per-cycle control word is pushed to
// a queue and popped against the DUT output at each falling clock edge.
module tb_mainfsm;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mainfsm_if bus ();

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (bus.Op),
    .Funct     (bus.Funct),
    .IRWrite   (bus.IRWrite),
    .AdrSrc    (bus.AdrSrc),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ResultSrc (bus.ResultSrc),
    .NextPC    (bus.NextPC),
    .RegW      (bus.RegW),
    .MemW      (bus.MemW),
    .Branch    (bus.Branch),
    .ALUOp     (bus.ALUOp),
    .State     (bus.State)
  );

  // Observed word: {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
  //                 NextPC, RegW, MemW, Branch, ALUOp}
  wire [16:0] w_obs = {bus.State, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ResultSrc, bus.NextPC, bus.RegW,
                       bus.MemW, bus.Branch, bus.ALUOp};

  // Scoreboard
  logic [16:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference control word for each state, written from the output table.
  function automatic logic [16:0] model(input logic [3:0] s);
    logic       ir, adr, npc, rw, mw, br, aop;
    logic [1:0] sa, sb, rs;
    ir = 0; adr = 0; npc = 0; rw = 0; mw = 0; br = 0; aop = 0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (s)
      4'd0: begin ir = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2: begin sb = 2'b01; end
      4'd3: begin adr = 1; end
      4'd4: begin rs = 2'b01; rw = 1; end
      4'd5: begin adr = 1; mw = 1; end
      4'd6: begin aop = 1; end
      4'd7: begin sb = 2'b01; aop = 1; end
      4'd8: begin rw = 1; end
      4'd9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1; end
      default: ;
    endcase
    return {s, ir, adr, sa, sb, rs, npc, rw, mw, br, aop};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs,
                       input logic [16:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected state walk of one instruction, starting at FETCH.
  task automatic push_instr(input logic [1:0] op, input logic [5:0] fn);
    exp_q.push_back(model(4'd0));
    exp_q.push_back(model(4'd1));
    case (op)
      2'b00: begin
        exp_q.push_back(model(fn[5] ? 4'd7 : 4'd6));
        exp_q.push_back(model(4'd8));
      end
      2'b01: begin
        exp_q.push_back(model(4'd2));
        if (fn[0]) begin
          exp_q.push_back(model(4'd3));
          exp_q.push_back(model(4'd4));
        end else begin
          exp_q.push_back(model(4'd5));
        end
      end
      2'b10:   exp_q.push_back(model(4'd9));
      default: exp_q.push_back(model(4'd10));
    endcase
  endtask

  // Driver: called at a falling edge with the DUT in FETCH; returns at the
  // falling edge where the next FETCH is visible.
  task automatic run_instr(input string tag, input logic [1:0] op,
                           input logic [5:0] fn);
    bus.Op    = op;
    bus.Funct = fn;
    push_instr(op, fn);
    while (exp_q.size() > 0) begin
      check(tag, w_obs, exp_q.pop_front());
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [5:0] rfn;
    reset     = 1'b1;
    bus.Op    = 2'b01;
    bus.Funct = 6'b011001;

    // Reset held: FETCH vector, no RegW/MemW/Branch.
    @(negedge clk);
    check("reset_hold0", w_obs, model(4'd0));
    @(negedge clk);
    check("reset_hold1", w_obs, model(4'd0));
    reset = 1'b0;

    // Directed instructions.
    run_instr("ldr",     2'b01, 6'b011001);
    run_instr("str",     2'b01, 6'b011000);
    run_instr("add_reg", 2'b00, 6'b001000);
    run_instr("add_imm", 2'b00, 6'b101000);
    run_instr("branch",  2'b10, 6'b000000);
    run_instr("op11",    2'b11, 6'b000000);

    // Asynchronous reset while in MEMWR.
    bus.Op    = 2'b01;
    bus.Funct = 6'b011000;
    push_instr(2'b01, 6'b011000);
    for (int k = 0; k < 4; k++) begin
      check("str_pre_rst", w_obs, exp_q.pop_front());
      if (k < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    #2 reset = 1'b1;
    #1 check("async_rst", w_obs, model(4'd0));
    @(posedge clk);
    @(negedge clk);
    check("rst_held_edge", w_obs, model(4'd0));
    reset = 1'b0;
    run_instr("after_rst", 2'b00, 6'b001000);

    // Random instruction mix.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom_range(0, 63));
      run_instr($sformatf("rand%0d", i), rop, rfn);
    end

    check("final_fetch", w_obs, model(4'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
